// File: rtl/pln_eval_if.sv
// Token-in / result-out bus of the postfix evaluator.
// The evaluator is the slave; the upstream/downstream side is the master.
interface pln_eval_if #(
    parameter int W = 16
);
    logic         TOK_VLD;
    logic [7:0]   TOK_DAT;
    logic         TOK_RDY;
    logic         RES_VLD;
    logic [W-1:0] RES_DAT;
    logic         RES_RDY;
    logic         ERR;
    logic [2:0]   ERR_CODE;

    modport master (
        output TOK_VLD, TOK_DAT, RES_RDY,
        input  TOK_RDY, RES_VLD, RES_DAT, ERR, ERR_CODE
    );

    modport slave (
        input  TOK_VLD, TOK_DAT, RES_RDY,
        output TOK_RDY, RES_VLD, RES_DAT, ERR, ERR_CODE
    );
endinterface

// File: rtl/pln_eval.sv
// Postfix (RPN) expression evaluator: single-digit operands, + - * /, '=' terminator.
// Operands live on a register stack; division is a W-cycle restoring divide on magnitudes.
module pln_eval #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic    CLK,
    input  logic    RST,
    pln_eval_if.slave bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(W);

    typedef enum logic [2:0] {IDLE, EXEC, DIV, DONE, ERROR} state_t;

    state_t         state_reg;
    logic [SPW-1:0] sp_reg;
    logic [W-1:0]   stack_reg [DEPTH];
    logic [W-1:0]   a_reg, b_reg;
    logic [7:0]     op_reg;
    logic [W-1:0]   quo_reg, rem_reg, dvs_reg;
    logic           neg_reg;
    logic [CW-1:0]  cnt_reg;
    logic           res_vld_reg;
    logic [W-1:0]   res_dat_reg;
    logic           err_reg;
    logic [2:0]     err_code_reg;

    // token decode
    logic       tok_rdy, tok_xfer;
    logic [7:0] tok;
    logic       is_digit, is_space, is_op, is_div, is_eq;

    assign tok      = bus.TOK_DAT;
    assign tok_rdy  = (state_reg == IDLE) || (state_reg == ERROR);
    assign tok_xfer = bus.TOK_VLD && tok_rdy;
    assign is_digit = (tok >= 8'h30) && (tok <= 8'h39);
    assign is_space = (tok == 8'h20);
    assign is_div   = (tok == 8'h2F);
    assign is_op    = (tok == 8'h2B) || (tok == 8'h2D) || (tok == 8'h2A) || is_div;
    assign is_eq    = (tok == 8'h3D);

    // stack top (B) and next (A) reads
    logic [SPW-1:0] sp_m1, sp_m2;
    logic [W-1:0]   top_val, nxt_val, abs_top, abs_nxt;
    logic           sp_full;

    assign sp_m1   = sp_reg - SPW'(1);
    assign sp_m2   = sp_reg - SPW'(2);
    assign top_val = stack_reg[sp_m1[IW-1:0]];
    assign nxt_val = stack_reg[sp_m2[IW-1:0]];
    assign abs_top = top_val[W-1] ? (~top_val + W'(1)) : top_val;
    assign abs_nxt = nxt_val[W-1] ? (~nxt_val + W'(1)) : nxt_val;
    assign sp_full = (sp_reg == SPW'(DEPTH));

    // one restoring-divide step; remainder stays below the divisor so bit W flags a borrow
    logic [W:0]   rem_sh, rem_sub;
    logic         q_bit;
    logic [W-1:0] quo_nx, rem_nx, div_res;

    assign rem_sh  = {rem_reg, quo_reg[W-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_reg};
    assign q_bit   = ~rem_sub[W];
    assign rem_nx  = q_bit ? rem_sub[W-1:0] : rem_sh[W-1:0];
    assign quo_nx  = {quo_reg[W-2:0], q_bit};
    assign div_res = neg_reg ? (~quo_nx + W'(1)) : quo_nx;

    logic [W-1:0] exec_res;
    always_comb begin
        exec_res = a_reg * b_reg;
        if (op_reg == 8'h2B) begin
            exec_res = a_reg + b_reg;
        end else if (op_reg == 8'h2D) begin
            exec_res = a_reg - b_reg;
        end
    end

    // stack write port: digit push, EXEC result, final DIV step
    logic         push_en;
    logic [W-1:0] push_val;
    always_comb begin
        push_en  = 1'b0;
        push_val = '0;
        case (state_reg)
            IDLE: begin
                push_en  = tok_xfer && is_digit && !sp_full;
                push_val = {{(W-8){1'b0}}, tok - 8'h30};
            end
            EXEC: begin
                push_en  = 1'b1;
                push_val = exec_res;
            end
            DIV: begin
                push_en  = (cnt_reg == CW'(W - 1));
                push_val = div_res;
            end
            default: begin
                push_en  = 1'b0;
                push_val = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stack
            always_ff @(posedge CLK) begin
                if (push_en && (sp_reg == SPW'(gi))) begin
                    stack_reg[gi] <= push_val;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            sp_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            dvs_reg      <= '0;
            neg_reg      <= 1'b0;
            cnt_reg      <= '0;
            res_vld_reg  <= 1'b0;
            res_dat_reg  <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    err_reg      <= 1'b0;
                    err_code_reg <= '0;
                    if (tok_xfer && !is_space) begin
                        if (is_digit) begin
                            if (sp_full) begin
                                state_reg    <= ERROR;
                                err_reg      <= 1'b1;
                                err_code_reg <= 3'd2;
                            end else begin
                                sp_reg <= sp_reg + SPW'(1);
                            end
                        end else if (is_op) begin
                            if (sp_reg < SPW'(2)) begin
                                state_reg    <= ERROR;
                                err_reg      <= 1'b1;
                                err_code_reg <= 3'd1;
                            end else begin
                                a_reg     <= nxt_val;
                                b_reg     <= top_val;
                                op_reg    <= tok;
                                sp_reg    <= sp_m2;
                                quo_reg   <= abs_nxt;
                                rem_reg   <= '0;
                                dvs_reg   <= abs_top;
                                neg_reg   <= nxt_val[W-1] ^ top_val[W-1];
                                cnt_reg   <= '0;
                                state_reg <= is_div ? DIV : EXEC;
                            end
                        end else if (is_eq) begin
                            if (sp_reg == SPW'(1)) begin
                                res_dat_reg <= top_val;
                                res_vld_reg <= 1'b1;
                                state_reg   <= DONE;
                            end else begin
                                // one-cycle pulse, evaluator stays ready for the next expression
                                err_reg      <= 1'b1;
                                err_code_reg <= 3'd5;
                                sp_reg       <= '0;
                            end
                        end else begin
                            state_reg    <= ERROR;
                            err_reg      <= 1'b1;
                            err_code_reg <= 3'd4;
                        end
                    end
                end
                EXEC: begin
                    sp_reg    <= sp_reg + SPW'(1);
                    state_reg <= IDLE;
                end
                DIV: begin
                    if ((cnt_reg == '0) && (dvs_reg == '0)) begin
                        state_reg    <= ERROR;
                        err_reg      <= 1'b1;
                        err_code_reg <= 3'd3;
                    end else begin
                        quo_reg <= quo_nx;
                        rem_reg <= rem_nx;
                        cnt_reg <= cnt_reg + CW'(1);
                        if (cnt_reg == CW'(W - 1)) begin
                            sp_reg    <= sp_reg + SPW'(1);
                            state_reg <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (bus.RES_RDY) begin
                        res_vld_reg <= 1'b0;
                        sp_reg      <= '0;
                        state_reg   <= IDLE;
                    end
                end
                ERROR: begin
                    if (tok_xfer && is_eq) begin
                        err_reg      <= 1'b0;
                        err_code_reg <= '0;
                        sp_reg       <= '0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.TOK_RDY  = tok_rdy;
    assign bus.RES_VLD  = res_vld_reg;
    assign bus.RES_DAT  = res_dat_reg;
    assign bus.ERR      = err_reg;
    assign bus.ERR_CODE = err_code_reg;
endmodule

// File: doc/pln_eval.md
Name: pln_eval

Overview:
- Downstream of the infix-to-postfix converter; consumes its 8-bit ASCII postfix token stream and evaluates the expression on an internal operand stack.
- Operands are single ASCII digits '0'..'9'. Operators are '+'(43), '-'(45), '*'(42), '/'(47). '='(61) terminates an expression.
- Emits one signed result per expression over a valid/ready handshake, or an error code.

Parameters:
- W, 16, operand/result width in bits, signed two's complement.
- DEPTH, 8, operand stack depth in entries (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- TOK_VLD  in  1  token valid.
- TOK_DAT  in  8  ASCII token.
- TOK_RDY  out  1  block can accept a token this cycle; a token transfers when TOK_VLD && TOK_RDY.
- RES_VLD  out  1  result valid; held until accepted.
- RES_DAT  out  W  signed result.
- RES_RDY  in  1  result consumer ready.
- ERR  out  1  error flag.
- ERR_CODE  out  3  1 underflow, 2 overflow, 3 divide-by-zero, 4 bad token, 5 bad depth at '='.

Behaviour:
- Reset (async): state IDLE, stack empty (sp=0), RES_VLD=0, RES_DAT=0, ERR=0, ERR_CODE=0. TOK_RDY=1 once reset deasserts. Reset mid-division or mid-result abandons all work.
- States: IDLE, EXEC, DIV, DONE, ERROR. TOK_RDY=1 only in IDLE and ERROR.
- IDLE, on token transfer:
  - Digit: push (TOK_DAT-48) zero-extended to W. Stays in IDLE, so one token is accepted per cycle. Push when sp==DEPTH goes to ERROR, code 2.
  - Space (32): ignored.
  - Operator with sp<2: go to ERROR, code 1.
  - Operator with sp>=2: latch A=stack[sp-2] and B=stack[sp-1], pop both. Go to EXEC for + - *, or DIV for /.
  - '=' with sp==1: RES_DAT<=top, RES_VLD<=1, go to DONE.
  - '=' with sp!=1: ERR=1 and ERR_CODE=5 for exactly one cycle, stack cleared, stay in IDLE.
  - Any other byte: go to ERROR, code 4.
- EXEC (1 cycle): push A op B, then return to IDLE.
  - Result is modulo 2^W. '*' keeps the low W bits of the product.
  - Operator accepted at cycle t gives TOK_RDY=1 again at t+2.
- DIV:
  - First cycle: if B==0, go to ERROR, code 3.
  - Otherwise run an iterative restoring divide on magnitudes, W cycles (t+1..t+W), then sign-fix and push. TOK_RDY=1 at t+W+1.
  - Quotient truncates toward zero. -2^(W-1)/-1 wraps to -2^(W-1). No remainder is output.
- DONE:
  - RES_VLD=1 and RES_DAT stable until RES_RDY=1.
  - On the handshake cycle: stack cleared, RES_VLD<=0, go to IDLE.
  - TOK_RDY=0 throughout, so the next expression stalls upstream.
- ERROR:
  - ERR=1 with ERR_CODE held.
  - Tokens are accepted and discarded until '=' transfers. The next cycle has ERR=0, ERR_CODE=0, stack cleared, state IDLE.
  - No RES_VLD for the errored expression.
- Stack: register array with sp ranging 0..DEPTH. Pop and push never occur in the same cycle.

Test Plan (W=16, DEPTH=8 unless stated):
- "34+2*=" at one token per cycle -> RES_VLD with RES_DAT=14. TOK_RDY is low for exactly 1 cycle after '+' and after '*'.
- "39-2/=" -> RES_DAT=0xFFFD (-3). TOK_RDY is low for 16 cycles after '/'. "93-4/=" -> 1.
- "99*9*9*9*=" -> RES_DAT=0xE6A9 (59049 wrapped). Hold RES_RDY=0 for 5 cycles -> RES_VLD and RES_DAT are stable and TOK_RDY=0. Release -> accepted, then "12+=" -> 3.
- "50/3=" -> ERR=1, code 3, from the cycle after '/'. '3' and '=' are consumed, then ERR=0. "12+=" -> 3.
- "+" as the first token -> code 1. "12=" -> one-cycle ERR with code 5, no result. "1a" -> code 4.
- DEPTH=4: "12345" -> code 2 on '5'. Assert RST during a DIV operation -> all outputs return to reset values immediately and "11+=" -> 2.
